pong_game_ctrl: RTL

- Game-flow sequencer for the VGA pong design. It owns the ball's run/freeze state, serves, score and lives.
- Sits between the frame-rate ball updater and the video path:
  - consumes the once-per-frame update strobe, paddle-hit and ball-Y information;
  - emits ball load/enable controls, a 3-digit BCD score, lives and a miss-flash overlay enable.
- All timing is counted in frames, not clocks.

---
 rtl/pong_pkg.sv | 24 ++
 rtl/bcd_counter3.sv | 17 +
 rtl/pong_game_ctrl.sv | 98 +++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// pong_pkg: shared state encoding, screen geometry and BCD helper for the pong design
package pong_pkg;
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_MISS  = 3'd3,
    ST_OVER  = 3'd4
  } state_t;
  localparam int PADDLE_Y         = 27 * 16;
  localparam int MISS_Y_DEF       = 472;
  localparam int SERVE_X_DEF      = 312;
  localparam int SERVE_Y_DEF      = 64;
  localparam int LIVES_DEF        = 3;
  localparam int SERVE_FRAMES_DEF = 60;
  localparam int MISS_FRAMES_DEF  = 90;
  // three-digit BCD increment that sticks at 999
  function automatic logic [11:0] bcd3_inc(input logic [11:0] v);
    return (v == 12'h999)      ? v :
           (v[3:0] != 4'd9)    ? v + 12'd1 :
           (v[7:4] != 4'd9)    ? {v[11:8], v[7:4] + 4'd1, 4'd0} :
                                 {v[11:8] + 4'd1, 8'h00};
  endfunction
endpackage

// File: rtl/bcd_counter3.sv
// bcd_counter3: saturating three-digit BCD score counter with clear
module bcd_counter3
  import pong_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_inc,
  input  logic        i_clr,
  output logic [11:0] o_bcd
);
  logic [11:0] r_bcd;
  always_ff @(posedge clk) begin
    if (reset || i_clr) r_bcd <= 12'h000;
    else if (i_inc) r_bcd <= bcd3_inc(r_bcd);
  end
  assign o_bcd = r_bcd;
endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: frame-counted game-flow sequencer owning serve, play, miss, score and lives
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int LIVES        = LIVES_DEF,
  parameter int SERVE_FRAMES = SERVE_FRAMES_DEF,
  parameter int MISS_FRAMES  = MISS_FRAMES_DEF,
  parameter int MISS_Y       = MISS_Y_DEF,
  parameter int SERVE_X      = SERVE_X_DEF,
  parameter int SERVE_Y      = SERVE_Y_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        start_btn,
  input  logic        paddle_hit,
  input  logic [8:0]  ball_y,
  output logic        ball_run,
  output logic        ball_load,
  output logic [9:0]  ball_init_x,
  output logic [8:0]  ball_init_y,
  output logic [11:0] score_bcd,
  output logic [2:0]  lives,
  output logic        flash,
  output logic [2:0]  game_state
);
  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] MISS_LAST  = 8'(MISS_FRAMES - 1);
  state_t     r_state;
  logic [7:0] r_cnt;
  logic [2:0] r_lives;
  logic       r_start_d, r_run, r_load, r_flash;
  logic       w_start_edge, w_hit, w_clr;
  logic [7:0] w_cnt_inc;
  assign w_start_edge = start_btn & ~r_start_d;
  assign w_hit        = paddle_hit & (r_state == ST_PLAY);
  assign w_clr        = start_btn & (r_state == ST_IDLE);
  assign w_cnt_inc    = r_cnt + 8'd1;
  bcd_counter3 u_score (
    .clk   (clk),
    .reset (reset),
    .i_inc (w_hit),
    .i_clr (w_clr),
    .o_bcd (score_bcd)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 8'd0;
      r_lives   <= 3'(LIVES);
      r_start_d <= 1'b0;
      r_run     <= 1'b0;
      r_load    <= 1'b0;
      r_flash   <= 1'b0;
    end else begin
      r_start_d <= start_btn;
      r_load    <= 1'b0;
      case (r_state)
        ST_IDLE: if (start_btn) begin
          r_state <= ST_SERVE;
          r_lives <= 3'(LIVES);
          r_load  <= 1'b1;
          r_cnt   <= 8'd0;
        end
        ST_SERVE: if (w_start_edge || (frame_tick && r_cnt == SERVE_LAST)) begin
          r_state <= ST_PLAY;
          r_run   <= 1'b1;
          r_cnt   <= 8'd0;
        end else if (frame_tick) r_cnt <= w_cnt_inc;
        ST_PLAY: if (frame_tick && ball_y >= 9'(MISS_Y)) begin
          r_state <= ST_MISS;
          r_run   <= 1'b0;
          if (r_lives != 3'd0) r_lives <= r_lives - 3'd1;
        end
        ST_MISS: if (frame_tick) begin
          if (r_cnt == MISS_LAST) begin
            r_cnt   <= 8'd0;
            r_flash <= 1'b0;
            r_state <= (r_lives == 3'd0) ? ST_OVER : ST_SERVE;
            r_load  <= (r_lives != 3'd0);
          end else begin
            r_cnt   <= w_cnt_inc;
            r_flash <= w_cnt_inc[3];
          end
        end
        ST_OVER: if (w_start_edge) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end
  assign ball_run    = r_run;
  assign ball_load   = r_load;
  assign ball_init_x = 10'(SERVE_X);
  assign ball_init_y = 9'(SERVE_Y);
  assign lives       = r_lives;
  assign flash       = r_flash;
  assign game_state  = r_state;
endmodule
